// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the 800x600@60 raster generator.
package vga_timing_pkg;

    // 800x600@60 Hz timing, 40 MHz pixel clock
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_H_TOTAL  = SVGA_H_ACTIVE + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;

    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;
    localparam int SVGA_V_TOTAL  = SVGA_V_ACTIVE + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

    // Request coordinate widths seen by the pixel source
    localparam int X_W = 11;
    localparam int Y_W = 10;

    // One sync/enable slot travelling down the alignment delay line
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    // Bits needed to hold values 0..n-1 (at least one bit)
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-source request/return bus plus the VGA output pins.
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int COLOR_W = 8
);
    logic                   pix_req;
    logic [X_W-1:0]         pix_x;
    logic [Y_W-1:0]         pix_y;
    logic                   frame_start;
    logic [3*COLOR_W-1:0]   rgb_in;
    logic                   vga_hs;
    logic                   vga_vs;
    logic                   vga_de;
    logic [3*COLOR_W-1:0]   vga_rgb;

    // Timing generator side
    modport master (
        output pix_req, pix_x, pix_y, frame_start,
        input  rgb_in,
        output vga_hs, vga_vs, vga_de, vga_rgb
    );

    // Pixel source / display side
    modport slave (
        input  pix_req, pix_x, pix_y, frame_start,
        output rgb_in,
        input  vga_hs, vga_vs, vga_de, vga_rgb
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single slow asynchronous level.
module sync_2ff
    import vga_timing_pkg::*;
#(
    parameter bit RST_VAL = 1'b0
)(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // Two back-to-back flops; only q is used downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: lock-gated counters, request stage, and a
// delay line that realigns sync/enable with pixel data returned by the source.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FP     = SVGA_H_FP,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BP     = SVGA_H_BP,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FP     = SVGA_V_FP,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BP     = SVGA_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int PIX_LAT  = 2,     // source latency, 0..8
    parameter int COLOR_W  = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare count of headroom so the sync stop compare always fits
    localparam int HC_W = cnt_w(H_TOTAL + 1);
    localparam int VC_W = cnt_w(V_TOTAL + 1);
    localparam int RGB_W = 3 * COLOR_W;

    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT    = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_START = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_STOP  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT    = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_START = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_STOP  = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_t SYNC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

    logic            lock_s;
    logic [HC_W-1:0] h_cnt;
    logic [VC_W-1:0] v_cnt;
    logic            in_active;
    logic            hs_lvl;
    logic            vs_lvl;
    sync_t           stage [0:PIX_LAT];

    sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Decode of the current counter position; vs changes only at line starts
    assign in_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_lvl    = ((h_cnt >= HS_START) && (h_cnt < HS_STOP)) ? HS_POL : ~HS_POL;
    assign vs_lvl    = ((v_cnt >= VS_START) && (v_cnt < VS_STOP)) ? VS_POL : ~VS_POL;

    // Raster counters, held at the origin whenever the PLL is not locked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!lock_s) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Request stage: registered coordinates and request to the pixel source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pix_req     <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.pix_x       <= '0;
            bus.pix_y       <= '0;
        end else if (!lock_s) begin
            bus.pix_req     <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.pix_x       <= '0;
            bus.pix_y       <= '0;
        end else begin
            bus.pix_req     <= in_active;
            bus.frame_start <= (h_cnt == '0) && (v_cnt == '0);
            bus.pix_x       <= X_W'(h_cnt);
            bus.pix_y       <= Y_W'(v_cnt);
        end
    end

    // Delay line: stage[0] sits alongside pix_req, stage[PIX_LAT] meets rgb_in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= PIX_LAT; i++) stage[i] <= SYNC_IDLE;
        end else if (!lock_s) begin
            for (int i = 0; i <= PIX_LAT; i++) stage[i] <= SYNC_IDLE;
        end else begin
            stage[0] <= '{hs: hs_lvl, vs: vs_lvl, de: in_active};
            for (int i = 1; i <= PIX_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    // Output register: colour is blanked to zero outside the display window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.vga_hs  <= ~HS_POL;
            bus.vga_vs  <= ~VS_POL;
            bus.vga_de  <= 1'b0;
            bus.vga_rgb <= '0;
        end else begin
            bus.vga_hs  <= stage[PIX_LAT].hs;
            bus.vga_vs  <= stage[PIX_LAT].vs;
            bus.vga_de  <= stage[PIX_LAT].de;
            bus.vga_rgb <= stage[PIX_LAT].de ? bus.rgb_in : {RGB_W{1'b0}};
        end
    end

endmodule
